// File: rtl/aes_sbox_pkg.sv
// Shared definitions for the AES S-box datapath slice: XOR-array widths,
// the result-register state encoding and a nibble parity helper.
package aes_sbox_pkg;

  localparam int XOR_KW = 32;  // operand width into the XOR array
  localparam int XOR_RW = 8;   // result width out of the XOR array

  // Result register occupancy
  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Even-parity of one 4-bit group (one XOR-array output bit)
  function automatic logic xor4(input logic [3:0] nib);
    return ^nib;
  endfunction

endpackage

// File: rtl/xor8_4.sv
// Eight independent 4-input XOR reductions. Input bit k[j] is K[j] of the
// array; output r[7-m] reduces K[4m .. 4m+3].
module xor8_4
  import aes_sbox_pkg::*;
(
  input  logic [XOR_KW-1:0] k,
  output logic [XOR_RW-1:0] r
);

  // Reduce each group of four consecutive K bits into one result bit
  always_comb begin
    r = {XOR_RW{1'b0}};
    for (int m = 0; m < XOR_RW; m++) begin
      r[XOR_RW-1-m] = xor4(k[4*m +: 4]);
    end
  end

endmodule

// File: rtl/xor8_4_rr_arbiter.sv
// Round-robin arbiter sharing one xor8_4 among NREQ requesters. A single
// registered result slot (EMPTY/FULL) is refilled in the same cycle it
// drains, so sustained throughput is one result per clock.
module xor8_4_rr_arbiter
  import aes_sbox_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*XOR_KW-1:0]   req_k,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XOR_RW-1:0]        out_r,
  output logic [IDW-1:0]           out_id
);

  out_state_e          state_r;
  out_state_e          state_next_s;
  logic [IDW-1:0]      rr_ptr_r;
  logic [IDW-1:0]      rr_ptr_next_s;
  logic [XOR_RW-1:0]   res_r;
  logic [IDW-1:0]      id_r;

  logic                grant_found_s;
  logic [IDW-1:0]      grant_idx_s;
  logic                can_accept_s;
  logic                accept_s;
  logic [XOR_KW-1:0]   op_s;
  logic [XOR_KW-1:0]   k_s;
  logic [XOR_RW-1:0]   xr_s;

  assign out_valid    = (state_r == OUT_FULL);
  assign out_r        = res_r;
  assign out_id       = id_r;

  // The slot can take new data when empty or when it drains this cycle
  assign can_accept_s = !out_valid || out_ready;
  assign accept_s     = grant_found_s && can_accept_s && !rst;

  // Rotating priority scan: first valid requester at or after rr_ptr
  always_comb begin
    logic [IDW:0] cand_v;
    logic         hit_v;
    grant_found_s = 1'b0;
    grant_idx_s   = {IDW{1'b0}};
    cand_v        = {(IDW+1){1'b0}};
    hit_v         = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand_v        = {1'b0, rr_ptr_r} + (IDW+1)'(off);
      cand_v        = (cand_v >= (IDW+1)'(NREQ)) ? (cand_v - (IDW+1)'(NREQ)) : cand_v;
      hit_v         = !grant_found_s && req_valid[cand_v[IDW-1:0]];
      grant_idx_s   = hit_v ? cand_v[IDW-1:0] : grant_idx_s;
      grant_found_s = grant_found_s || hit_v;
    end
  end

  // One-hot ready to the grantee, only on an actual accept
  always_comb begin
    req_ready = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept_s && (grant_idx_s == IDW'(i));
    end
  end

  // Pointer moves just past the grantee, wrapping after the last requester
  always_comb begin
    if (grant_idx_s == IDW'(NREQ - 1)) begin
      rr_ptr_next_s = {IDW{1'b0}};
    end else begin
      rr_ptr_next_s = grant_idx_s + IDW'(1'b1);
    end
  end

  // Select the grantee's operand and bit-reverse it into K order
  always_comb begin
    op_s = req_k[XOR_KW*int'(grant_idx_s) +: XOR_KW];
    k_s  = {XOR_KW{1'b0}};
    for (int j = 0; j < XOR_KW; j++) begin
      k_s[j] = op_s[XOR_KW-1-j];
    end
  end

  xor8_4 u_xor8_4 (
    .k (k_s),
    .r (xr_s)
  );

  // Result slot next-state: fill on accept, drain on out_ready without refill
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      OUT_EMPTY: begin
        if (accept_s) begin
          state_next_s = OUT_FULL;
        end else begin
          state_next_s = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        if (accept_s) begin
          state_next_s = OUT_FULL;
        end else if (out_ready) begin
          state_next_s = OUT_EMPTY;
        end else begin
          state_next_s = OUT_FULL;
        end
      end
      default: state_next_s = OUT_EMPTY;
    endcase
  end

  // State, pointer and result registers; reset discards any pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= OUT_EMPTY;
      rr_ptr_r <= {IDW{1'b0}};
      res_r    <= {XOR_RW{1'b0}};
      id_r     <= {IDW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        rr_ptr_r <= rr_ptr_next_s;
        res_r    <= xr_s;
        id_r     <= grant_idx_s;
      end
    end
  end

endmodule

// File: tb/tb_xor8_4_rr_arbiter.sv
// Self-checking bench for xor8_4_rr_arbiter: directed scenarios plus a
// randomized run against a behavioural arbitration model.
module tb_xor8_4_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*32-1:0]   req_k;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_r;
  logic [IDW-1:0]       out_id;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit       m_valid = 1'b0;
  bit [7:0] m_res   = 8'h00;
  int       m_id    = 0;
  int       m_ptr   = 0;

  xor8_4_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_k     (req_k),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  // Result bit m is the parity of nibble m of the operand
  function automatic bit [7:0] ref_xor(input bit [31:0] op);
    bit [7:0] v;
    for (int m = 0; m < 8; m++) v[m] = ($countones(op[4*m +: 4]) % 2) == 1;
    return v;
  endfunction

  function automatic int exp_grant(input bit [NREQ-1:0] v, input int ptr);
    for (int off = 0; off < NREQ; off++) begin
      if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit [NREQ-1:0] exp_ready();
    int g;
    bit [NREQ-1:0] r;
    r = '0;
    g = exp_grant(req_valid, m_ptr);
    if (!rst && g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock and the model with it
  task automatic tick();
    int g;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_res = 8'h00; m_id = 0; m_ptr = 0;
    end else begin
      g = exp_grant(req_valid, m_ptr);
      if (g >= 0 && (!m_valid || out_ready)) begin
        m_valid = 1'b1;
        m_res   = ref_xor(req_k[32*g +: 32]);
        m_id    = g;
        m_ptr   = (g + 1) % NREQ;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) req_k[32*i +: 32] = $urandom;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_checks++;
      if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_r !== 8'h00 || out_id !== 2'd0)
        $display("FAIL reset_out: got v=%b r=%h id=%0d expected v=0 r=00 id=0", out_valid, out_r, out_id);
      else n_pass++;
    end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_bitmap();
    bit [31:0] ops [4];
    bit [7:0]  exps [4];
    ops  = '{32'h0000_0001, 32'h8000_0000, 32'h1111_1111, 32'hF000_0000};
    exps = '{8'h01, 8'h80, 8'hFF, 8'h00};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'b0001;
      req_k[31:0] = ops[i];
      #2;
      n_checks++;
      if (req_ready !== 4'b0001) $display("FAIL bitmap_ready: got %b expected 0001", req_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_r !== exps[i] || out_id !== 2'd0)
        $display("FAIL bitmap_out: got v=%b r=%h id=%0d expected v=1 r=%h id=0", out_valid, out_r, out_id, exps[i]);
      else n_pass++;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    bit [31:0] held;
    do_reset();
    req_valid = '1; out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #2;
      n_checks++;
      if (req_ready !== 4'(1 << (c % NREQ)))
        $display("FAIL rr_grant: got %b expected %b", req_ready, 4'(1 << (c % NREQ)));
      else n_pass++;
      held = req_k[32*(c % NREQ) +: 32];
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(c % NREQ) || out_r !== ref_xor(held))
        $display("FAIL rr_out: got v=%b id=%0d r=%h expected v=1 id=%0d r=%h",
                 out_valid, out_id, out_r, c % NREQ, ref_xor(held));
      else n_pass++;
      req_k[32*(c % NREQ) +: 32] = $urandom;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    bit [31:0] k0, k1, k2;
    k0 = $urandom; k1 = $urandom; k2 = $urandom;
    do_reset();
    req_valid = 4'b0001; req_k[31:0] = k0;
    tick();
    req_valid = 4'b0110; out_ready = 1'b0;
    req_k[32 +: 32] = k1; req_k[64 +: 32] = k2; req_k[31:0] = $urandom;
    for (int c = 0; c < 5; c++) begin
      #2;
      n_checks++;
      if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_r !== ref_xor(k0) || out_id !== 2'd0)
        $display("FAIL bp_hold: got rdy=%b v=%b r=%h id=%0d expected rdy=0000 v=1 r=%h id=0",
                 req_ready, out_valid, out_r, out_id, ref_xor(k0));
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #2;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL bp_release1: got %b expected 0010", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_id !== 2'd1 || out_r !== ref_xor(k1))
      $display("FAIL bp_out1: got id=%0d r=%h expected id=1 r=%h", out_id, out_r, ref_xor(k1));
    else n_pass++;
    req_valid = 4'b0100;
    #2;
    n_checks++;
    if (req_ready !== 4'b0100) $display("FAIL bp_release2: got %b expected 0100", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_id !== 2'd2 || out_r !== ref_xor(k2))
      $display("FAIL bp_out2: got id=%0d r=%h expected id=2 r=%h", out_id, out_r, ref_xor(k2));
    else n_pass++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0010;
    #2;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL sparse_req1: got %b expected 0010", req_ready);
    else n_pass++;
    tick();
    req_valid = 4'b1000;
    #2;
    n_checks++;
    if (req_ready !== 4'b1000) $display("FAIL sparse_req3: got %b expected 1000", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_id !== 2'd3) $display("FAIL sparse_id3: got %0d expected 3", out_id);
    else n_pass++;
    req_valid = 4'b1111;
    #2;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL wrap_grant: got %b expected 0001", req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL drain_empty: got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_valid = 4'b0100;
    tick();
    out_ready = 1'b0; req_valid = 4'b1010;
    tick();
    rst = 1'b1;
    #2;
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL midrst_ready: got %b expected 0000", req_ready);
    else n_pass++;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", out_valid);
    else n_pass++;
    #2;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL midrst_grant: got %b expected 0010", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd1)
      $display("FAIL midrst_out: got v=%b id=%0d expected v=1 id=1", out_valid, out_id);
    else n_pass++;
    req_valid = '0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit [NREQ-1:0] granted;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_k[32*i +: 32] = $urandom;
        end
      end
      #2;
      granted = exp_ready();
      n_checks++;
      if (req_ready !== granted || out_valid !== m_valid || (m_valid && (out_r !== m_res || out_id !== 2'(m_id))))
        $display("FAIL random_cycle%0d: got rdy=%b v=%b r=%h id=%0d expected rdy=%b v=%b r=%h id=%0d",
                 c, req_ready, out_valid, out_r, out_id, granted, m_valid, m_res, m_id);
      else n_pass++;
      tick();
      req_valid = req_valid & ~granted;
    end
    rst = 1'b0; req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_k = '0; out_ready = 1'b1;
    test_reset();
    test_bitmap();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
